// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Requester encoding doubles as the read-response source tag.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

  localparam logic REQ_CORE   = 1'b0;
  localparam logic REQ_LOADER = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker.
// On contention the requester that was not granted last wins.
module rr_pick2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: core (r0) and loader/debug (r1).
// Round-robin on contention, optional burst lock, one-cycle read latency.
//
// state | meaning
// ARB   | round-robin between r0 and r1
// LOCK0 | r0 holds a burst lock; only r0 can be granted
// LOCK1 | r1 holds a burst lock; only r1 can be granted
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_valid,
  input  logic              r0_we,
  input  logic              r0_lock,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  input  logic              r1_valid,
  input  logic              r1_we,
  input  logic              r1_lock,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r0_ready,
  output logic              r1_ready,
  output logic              r0_rvalid,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              core_stall
);

  arb_state_t        r_state;
  logic              r_last;
  logic              r_pend_v;
  logic              r_pend_tag;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;

  logic [1:0]        w_valid;
  logic [1:0]        w_pick;
  logic [1:0]        w_grant;
  logic              w_acc;
  logic              w_sel;
  logic              w_we;
  logic              w_lock;

  assign w_valid = {r1_valid, r0_valid};

  rr_pick2 u_pick (
    .valid (w_valid),
    .last  (r_last),
    .grant (w_pick)
  );

  // Grants are gated by reset so nothing reaches memory while it is held.
  always_comb begin
    w_grant = 2'b00;
    if (reset) begin
      case (r_state)
        ARB:     w_grant = w_pick;
        LOCK0:   w_grant = {1'b0, r0_valid};
        LOCK1:   w_grant = {r1_valid, 1'b0};
        default: w_grant = 2'b00;
      endcase
    end
  end

  assign w_acc  = |w_grant;
  assign w_sel  = w_grant[1];
  assign w_we   = w_sel ? r1_we   : r0_we;
  assign w_lock = w_sel ? r1_lock : r0_lock;

  assign r0_ready   = w_grant[0];
  assign r1_ready   = w_grant[1];
  assign mem_wr     = w_acc & w_we;
  assign mem_rd     = w_acc & ~w_we;
  assign mem_addr   = w_acc ? (w_sel ? r1_addr  : r0_addr)  : '0;
  assign mem_wdata  = w_acc ? (w_sel ? r1_wdata : r0_wdata) : '0;
  assign core_stall = reset & r0_valid & ~w_grant[0];

  assign r0_rvalid = r_pend_v & (r_pend_tag == REQ_CORE);
  assign r1_rvalid = r_pend_v & (r_pend_tag == REQ_LOADER);
  assign r0_rdata  = r0_rvalid ? mem_rdata : r_rdata0;
  assign r1_rdata  = r1_rvalid ? mem_rdata : r_rdata1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ARB;
      r_last     <= REQ_LOADER;  // "last = loader" makes the core win first contention
      r_pend_v   <= 1'b0;
      r_pend_tag <= REQ_CORE;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
    end else begin
      r_pend_v <= mem_rd;
      if (mem_rd)    r_pend_tag <= w_sel;
      if (r0_rvalid) r_rdata0   <= mem_rdata;
      if (r1_rvalid) r_rdata1   <= mem_rdata;
      if (w_acc)     r_last     <= w_sel;

      case (r_state)
        ARB: begin
          if (w_acc && w_lock) r_state <= w_sel ? LOCK1 : LOCK0;
        end
        // While locked a valid owner is always accepted, so dropping
        // lock or valid both end the burst.
        LOCK0: begin
          if (!r0_valid || !r0_lock) r_state <= ARB;
        end
        LOCK1: begin
          if (!r1_valid || !r1_lock) r_state <= ARB;
        end
        default: r_state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a transaction-level model predicts every
// output each cycle; literal checks pin the headline scenarios.
module tb_dmem_arbiter;

  localparam int DW = 32;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          r0_valid = 1'b0, r0_we = 1'b0, r0_lock = 1'b0;
  logic [AW-1:0] r0_addr = '0;
  logic [DW-1:0] r0_wdata = '0;
  logic          r1_valid = 1'b0, r1_we = 1'b0, r1_lock = 1'b0;
  logic [AW-1:0] r1_addr = '0;
  logic [DW-1:0] r1_wdata = '0;
  logic          r0_ready, r1_ready, r0_rvalid, r1_rvalid;
  logic [DW-1:0] r0_rdata, r1_rdata;
  logic          mem_wr, mem_rd, core_stall;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  int n_vec = 0;
  int n_mis = 0;

  dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_we(r0_we), .r0_lock(r0_lock),
    .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r1_valid(r1_valid), .r1_we(r1_we), .r1_lock(r1_lock),
    .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r0_ready(r0_ready), .r1_ready(r1_ready),
    .r0_rvalid(r0_rvalid), .r1_rvalid(r1_rvalid),
    .r0_rdata(r0_rdata), .r1_rdata(r1_rdata),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .core_stall(core_stall)
  );

  always #5 clk = ~clk;

  // Environment memory: one-cycle registered read.
  logic [DW-1:0] env_mem [0:511];
  always @(posedge clk) begin
    if (mem_wr) env_mem[mem_addr] <= mem_wdata;
    if (mem_rd) mem_rdata <= env_mem[mem_addr];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  int            m_owner;
  int            m_last;
  bit            m_rv [2];
  logic [DW-1:0] m_pdata;
  logic [DW-1:0] m_hold [2];
  logic [DW-1:0] m_mem [0:511];

  function automatic logic f_v(int n);
    return n == 0 ? r0_valid : (n == 1 ? r1_valid : 1'b0);
  endfunction
  function automatic logic f_we(int n);
    return n == 0 ? r0_we : (n == 1 ? r1_we : 1'b0);
  endfunction
  function automatic logic f_lk(int n);
    return n == 0 ? r0_lock : (n == 1 ? r1_lock : 1'b0);
  endfunction
  function automatic logic [AW-1:0] f_a(int n);
    return n == 0 ? r0_addr : (n == 1 ? r1_addr : '0);
  endfunction
  function automatic logic [DW-1:0] f_wd(int n);
    return n == 0 ? r0_wdata : (n == 1 ? r1_wdata : '0);
  endfunction

  function automatic int m_grant();
    if (m_owner >= 0) return f_v(m_owner) ? m_owner : -1;
    if (r0_valid && r1_valid) return 1 - m_last;
    if (r0_valid) return 0;
    if (r1_valid) return 1;
    return -1;
  endfunction

  always @(posedge clk or negedge reset) begin : model
    int g;
    if (!reset) begin
      m_owner = -1;
      m_last  = 1;
      m_rv    = '{default: 1'b0};
      m_hold  = '{default: '0};
      m_pdata = '0;
    end else begin
      g = m_grant();
      for (int n = 0; n < 2; n++) begin
        if (m_rv[n]) m_hold[n] = m_pdata;
        m_rv[n] = 1'b0;
      end
      if (g >= 0) begin
        if (f_we(g)) m_mem[f_a(g)] = f_wd(g);
        else begin
          m_rv[g] = 1'b1;
          m_pdata = m_mem[f_a(g)];
        end
      end
      if (m_owner < 0) begin
        if (g >= 0 && f_lk(g)) m_owner = g;
      end else if (!f_v(m_owner) || !f_lk(m_owner)) begin
        m_owner = -1;
      end
      if (g >= 0) m_last = g;
    end
  end

  // Per-cycle observations for the literal checks.
  logic seen_r0, seen_r1, seen_stall;

  always @(negedge clk) begin : compare
    int            g;
    logic [6:0]    e7;
    logic [DW-1:0] e0, e1;
    g  = reset ? m_grant() : -1;
    e7 = {g == 0, g == 1, g >= 0 && !f_we(g), g >= 0 && f_we(g),
          reset && r0_valid && g != 0, reset && m_rv[0], reset && m_rv[1]};
    e0 = !reset ? '0 : (m_rv[0] ? m_pdata : m_hold[0]);
    e1 = !reset ? '0 : (m_rv[1] ? m_pdata : m_hold[1]);
    chk("ctrl{rdy0,rdy1,rd,wr,stall,rv0,rv1}",
        64'({r0_ready, r1_ready, mem_rd, mem_wr, core_stall, r0_rvalid, r1_rvalid}), 64'(e7));
    chk("rdata{r0,r1}", {r0_rdata, r1_rdata}, {e0, e1});
    if (g >= 0)
      chk("cmd{addr,wdata}", 64'({mem_addr, mem_wdata}), 64'({f_a(g), f_wd(g)}));
    else if (!reset)
      chk("cmd_in_reset{addr,wdata}", 64'({mem_addr, mem_wdata}), 64'(0));
    seen_r0    = r0_ready;
    seen_r1    = r1_ready;
    seen_stall = core_stall;
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic v0, we0, lk0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic v1, we1, lk1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    r0_valid = v0; r0_we = we0; r0_lock = lk0; r0_addr = a0; r0_wdata = d0;
    r1_valid = v1; r1_we = we1; r1_lock = lk1; r1_addr = a1; r1_wdata = d1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] eg [5];
    logic       es [5];
    for (int i = 0; i < 512; i++) begin
      env_mem[i] = '0;
      m_mem[i]   = '0;
    end
    env_mem[9'h010] = 32'hDEADBEEF;
    m_mem[9'h010]   = 32'hDEADBEEF;
    env_mem[9'h011] = 32'h11112222;
    m_mem[9'h011]   = 32'h11112222;

    // Reset held with busy inputs: nothing may leak out.
    reset = 1'b0;
    drive(1, 0, 1, 9'h010, 32'h1, 1, 1, 1, 9'h011, 32'h2);
    drive(1, 1, 0, 9'h012, 32'h3, 1, 0, 0, 9'h013, 32'h4);
    chk("reset_outputs", 64'({r0_ready, r1_ready, mem_rd, mem_wr, core_stall, r0_rvalid, r1_rvalid}), 64'(0));
    reset = 1'b1;

    // Contention round-robin, starting from the post-reset pointer.
    eg[0] = 2'b01; eg[1] = 2'b10; eg[2] = 2'b01; eg[3] = 2'b10;
    es[0] = 1'b0;  es[1] = 1'b1;  es[2] = 1'b0;  es[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 9'h010, '0, 1, 0, 0, 9'h011, '0);
      chk($sformatf("rr_grant_c%0d", i + 1), 64'({seen_r1, seen_r0}), 64'(eg[i]));
      chk($sformatf("rr_stall_c%0d", i + 1), 64'(seen_stall), 64'(es[i]));
    end
    idle();
    idle();

    // Lone core read.
    drive(1, 0, 0, 9'h010, '0, 0, 0, 0, '0, '0);
    chk("solo_read_ready_stall", 64'({seen_r0, seen_stall}), 64'(2'b10));
    chk("solo_read_resp", 64'({r0_rvalid, r0_rdata}), 64'({1'b1, 32'hDEADBEEF}));
    idle();

    // Core write, loader reads the same word next cycle.
    drive(1, 1, 0, 9'h020, 32'h55, 0, 0, 0, '0, '0);
    drive(0, 0, 0, '0, '0, 1, 0, 0, 9'h020, '0);
    chk("wr_then_rd_resp", 64'({r0_rvalid, r1_rvalid, r1_rdata}), 64'({2'b01, 32'h00000055}));
    idle();

    // Loader burst lock against a continuously valid core.
    drive(1, 1, 0, 9'h030, 32'hAA, 0, 0, 0, '0, '0);
    eg[0] = 2'b10; eg[1] = 2'b10; eg[2] = 2'b10; eg[3] = 2'b10; eg[4] = 2'b01;
    es[0] = 1'b1;  es[1] = 1'b1;  es[2] = 1'b1;  es[3] = 1'b1;  es[4] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive(1, 0, 0, 9'h000, '0, 1, 1, logic'(i < 3), AW'(9'h100 + i), DW'(32'h1000 + i));
      else       drive(1, 0, 0, 9'h000, '0, 0, 0, 0, '0, '0);
      chk($sformatf("lock_grant_c%0d", i + 1), 64'({seen_r1, seen_r0}), 64'(eg[i]));
      chk($sformatf("lock_stall_c%0d", i + 1), 64'(seen_stall), 64'(es[i]));
    end
    idle();
    drive(0, 0, 0, '0, '0, 1, 0, 0, 9'h101, '0);
    chk("lock_write_readback", 64'(r1_rdata), 64'(32'h1001));
    idle();

    // Lock released by the owner dropping valid: that cycle grants nobody.
    drive(1, 1, 0, 9'h031, 32'hBB, 0, 0, 0, '0, '0);
    drive(1, 0, 0, 9'h000, '0, 1, 1, 1, 9'h040, 32'h40);
    drive(1, 0, 0, 9'h000, '0, 0, 0, 0, '0, '0);
    chk("lock_drop_no_grant", 64'({seen_r1, seen_r0, seen_stall}), 64'(3'b001));
    drive(1, 0, 0, 9'h000, '0, 0, 0, 0, '0, '0);
    chk("lock_drop_core_next", 64'({seen_r1, seen_r0, seen_stall}), 64'(3'b010));
    idle();

    // Reset asserted right after an accepted read: response is discarded.
    drive(1, 0, 0, 9'h010, '0, 0, 0, 0, '0, '0);
    reset = 1'b0;
    #1;
    chk("midread_reset_outputs",
        64'({r0_ready, r1_ready, mem_rd, mem_wr, core_stall, r0_rvalid, r1_rvalid, r0_rdata}), 64'(0));
    drive(1, 0, 0, 9'h010, '0, 1, 1, 0, 9'h050, 32'h5);
    drive(1, 0, 0, 9'h010, '0, 1, 1, 0, 9'h050, 32'h5);
    reset = 1'b1;
    idle();
    chk("post_reset_no_rvalid", 64'({r0_rvalid, r1_rvalid, r0_rdata}), 64'(0));
    drive(1, 0, 0, 9'h011, '0, 0, 0, 0, '0, '0);
    chk("post_reset_first_accept", 64'(seen_r0), 64'(1));
    chk("post_reset_read_data", 64'({r0_rvalid, r0_rdata}), 64'({1'b1, 32'h11112222}));
    idle();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width.
REQ-002 SHALL have parameter ADDR_W, default 9, data-memory address width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have ports r0_valid/r0_we/r0_lock  input  1 each  core request, write-enable, and burst lock.
REQ-006 SHALL have ports r0_addr  input  ADDR_W  and  r0_wdata  input  DATA_W  core address and write data.
REQ-007 SHALL have ports r1_valid/r1_we/r1_lock, r1_addr, r1_wdata with the same widths: loader/debug requester.
REQ-008 SHALL have ports r0_ready, r1_ready  output  1  request accepted this cycle.
REQ-009 SHALL have ports r0_rvalid, r1_rvalid  output  1  and  r0_rdata, r1_rdata  output  DATA_W  read response.
REQ-010 SHALL have ports mem_wr, mem_rd  output  1,  mem_addr  output  ADDR_W,  mem_wdata  output  DATA_W  memory command.
REQ-011 SHALL have port mem_rdata  input  DATA_W  read data, valid exactly one cycle after mem_rd.
REQ-012 SHALL have port core_stall  output  1  = r0_valid & ~r0_ready.

Function
REQ-013 SHALL issue at most one memory command per cycle; mem_rd and mem_wr are never both 1.
REQ-014 SHALL accept requester N (rN_ready=1) only while rN_valid=1; command signals drive combinationally from the granted requester in that same cycle.
REQ-015 SHALL, in state ARB with one valid requester, grant it without a bubble.
REQ-016 SHALL, in ARB with both valid, grant the requester not granted last (round-robin); the pointer after reset favours r0.
REQ-017 SHALL update the round-robin pointer only on an accepted request.
REQ-018 SHALL move ARB->LOCKn when requester n is accepted with rn_lock=1; in LOCKn only requester n can be granted.
REQ-019 SHALL leave LOCKn -> ARB on the first accepted rn request with rn_lock=0, or any cycle with rn_valid=0 (lock dropped).
REQ-020 SHALL, for an accepted read, assert rN_rvalid for exactly one cycle, one cycle later, with rN_rdata=mem_rdata; the other rvalid stays 0.
REQ-021 SHALL hold rN_rdata at the last returned value when rN_rvalid=0.
REQ-022 SHALL produce no rvalid for writes; a write and a read in consecutive cycles (either requester) both complete in order.
REQ-023 SHALL tolerate back-to-back reads: one accepted read per cycle, responses routed by a one-bit registered source tag.
REQ-024 SHALL ignore rN_we, rN_addr, rN_wdata when rN_valid=0.

Reset
REQ-025 SHALL, while reset=0, force state ARB, pointer=r0, r0_rvalid=r1_rvalid=0, rdata registers=0, pending tag cleared.
REQ-026 SHALL, while reset=0, drive mem_wr=mem_rd=0, r0_ready=r1_ready=0, core_stall=0 regardless of inputs.
REQ-027 SHALL discard a read in flight when reset asserts mid-operation; no rvalid follows deassertion.
REQ-028 SHALL accept requests on the first rising edge after reset deasserts.

Structure
REQ-029 SHALL place arb_state_t (ARB, LOCK0, LOCK1) and REQ_CORE=0/REQ_LOADER=1 constants in package dmem_arb_pkg.
REQ-030 SHALL use one sub-module, rr_pick2: combinational two-way round-robin picker (valid[1:0], last -> grant[1:0]).

Verification
REQ-031 Only r0 reads addr 0x010 (mem holds 0xDEADBEEF) -> r0_ready same cycle, r0_rvalid=1 and r0_rdata=0xDEADBEEF next cycle, core_stall=0.
REQ-032 Both valid every cycle, no lock, 4 cycles -> grants r0,r1,r0,r1; core_stall=1 on cycles 2 and 4.
REQ-033 r1 locks for writes to 0x100..0x103 while r0 continuously valid -> 4 consecutive r1 grants, r0 granted in cycle 5.
REQ-034 r0 write 0x55 to 0x020 then r1 read 0x020 next cycle -> r1_rdata=0x00000055, r0_rvalid stays 0.
REQ-035 reset=0 asserted the cycle after an accepted r0 read -> no r0_rvalid after release; all outputs 0 during reset.
